uart_variable_tx: RTL
=====================

UART_VARIABLE_TX -- requirements
Module: uart_variable_tx

Interface
REQ-001 SHALL have parameter DEFAULT_PERIOD, default 217; clocks-per-bit used when i_Period is 0 (115200 baud at 25 MHz).
REQ-002 SHALL have port i_Clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-003 SHALL have port i_Reset, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port i_Period, input, 20 bits; clocks per bit (clock rate / baud rate).
REQ-005 SHALL have port i_TX_DV, input, 1 bit; one-cycle request to send i_TX_Byte.
REQ-006 SHALL have port i_TX_Byte, input, 8 bits; byte to transmit, sampled with i_TX_DV.
REQ-007 SHALL have port o_TX_Serial, output, 1 bit; UART line, idle high.
REQ-008 SHALL have port o_TX_Active, output, 1 bit; high while a frame is on the line.
REQ-009 SHALL have port o_TX_Done, output, 1 bit; one-cycle pulse at frame end.

Function
REQ-010 SHALL transmit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-011 SHALL use states IDLE, START, DATA, STOP; IDLE->START on accepted request; START->DATA, DATA->STOP after bit 7, STOP->IDLE, each transition after exactly P clocks in the current bit.
REQ-012 SHALL accept i_TX_DV only in IDLE; i_TX_DV in any other state is ignored without side effects.
REQ-013 SHALL latch i_TX_Byte and i_Period into internal registers on the accepting edge; later changes to either input SHALL NOT affect the frame in progress.
REQ-014 SHALL substitute DEFAULT_PERIOD for a latched i_Period of 0; P=1 is legal and yields one clock per bit.
REQ-015 SHALL drive o_TX_Serial low starting the cycle after the accepting edge (1-cycle latency); all outputs registered.
REQ-016 SHALL hold every bit, start and stop included, for exactly P clocks; frame length 10*P clocks.
REQ-017 SHALL use a 20-bit clock counter that counts 0..P-1 and wraps to 0 at each bit boundary; a 3-bit index that wraps 7->0 on DATA exit.
REQ-018 SHALL hold o_TX_Active high from the first start-bit cycle through the last stop-bit cycle inclusive, low otherwise.
REQ-019 SHALL pulse o_TX_Done for exactly one cycle, namely the first IDLE cycle after STOP.
REQ-020 SHALL accept an i_TX_DV arriving in the o_TX_Done cycle, giving back-to-back frames with no extra idle time.
REQ-021 SHALL hold o_TX_Serial high in IDLE and STOP.

Reset
REQ-022 SHALL, on i_Reset high at a clock edge, enter IDLE with o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, counters=0; a frame in progress is abandoned and never completes.
REQ-023 SHALL give i_Reset priority over a simultaneous i_TX_DV, which is dropped.

Structure
REQ-024 SHALL put the state encoding, the period width (20) and DEFAULT_PERIOD in the shared uart package used by receiver and transmitter.
REQ-025 SHALL have the option of one sub-module, uart_bit_timer (period counter with bit-boundary strobe); otherwise flat.

Verification
REQ-026 SHALL check: P=217, byte 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each 217 clocks; Done pulse 2171 cycles after the accepting edge.
REQ-027 SHALL check: i_Period=0, byte 0xA3 -> same timing as P=217; data bits 1,1,0,0,0,1,0,1.
REQ-028 SHALL check: P=4, byte 0x0F, i_Period changed to 8 and i_TX_DV with 0xFF pulsed mid-frame -> frame stays 40 clocks with data 0x0F; the second request is lost.
REQ-029 SHALL check: i_TX_DV with 0x81 in the Done cycle of the previous frame -> next start bit follows immediately; no high gap beyond the P-clock stop bit.
REQ-030 SHALL check: i_Reset asserted in DATA bit 3 -> the next cycle shows Serial=1, Active=0, no Done; a new request then transmits correctly.
REQ-031 SHALL check: P=1, byte 0x01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/uart_variable_tx_pkg.sv
// Shared UART definitions: state encoding, bit-period width and default baud divisor.
// Used by both the transmitter and the receiver.
package uart_variable_tx_pkg;

  localparam int PERIOD_W = 20;
  localparam int unsigned DEFAULT_PERIOD_C = 217;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A requested period of zero selects the build-time default divisor.
  function automatic logic [PERIOD_W-1:0] effective_period(
    input logic [PERIOD_W-1:0] req,
    input logic [PERIOD_W-1:0] dflt
  );
    return (req == '0) ? dflt : req;
  endfunction

endpackage

// File: rtl/uart_variable_tx_if.sv
// Request/status bundle for the variable-rate UART transmitter.
interface uart_variable_tx_if;
  import uart_variable_tx_pkg::*;

  logic [PERIOD_W-1:0] period;
  logic                tx_dv;
  logic [7:0]          tx_byte;
  logic                tx_serial;
  logic                tx_active;
  logic                tx_done;

  modport master (
    output period, tx_dv, tx_byte,
    input  tx_serial, tx_active, tx_done
  );

  modport slave (
    input  period, tx_dv, tx_byte,
    output tx_serial, tx_active, tx_done
  );
endinterface

// File: rtl/uart_variable_tx.sv
// 8N1 UART transmitter with a per-frame clocks-per-bit divisor latched at request time.
// All outputs are registered from the next-state values, so the line follows the request by one cycle.
module uart_variable_tx
  import uart_variable_tx_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [PERIOD_W-1:0] i_Period,
  input  logic                i_TX_DV,
  input  logic [7:0]          i_TX_Byte,
  output logic                o_TX_Serial,
  output logic                o_TX_Active,
  output logic                o_TX_Done
);

  localparam logic [PERIOD_W-1:0] DEFAULT_P = PERIOD_W'(DEFAULT_PERIOD);

  tx_state_t           state_reg, state_next;
  logic [PERIOD_W-1:0] count_reg, count_next;
  logic [PERIOD_W-1:0] period_reg, period_next;
  logic [2:0]          index_reg, index_next;
  logic [7:0]          data_reg, data_next;
  logic                serial_reg, serial_next;
  logic                active_reg, active_next;
  logic                done_reg, done_next;
  logic                bit_end;

  assign bit_end = (count_reg == period_reg - PERIOD_W'(1));

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    period_next = period_reg;
    index_next  = index_reg;
    data_next   = data_reg;

    case (state_reg)
      IDLE: begin
        if (i_TX_DV) begin
          state_next  = START;
          data_next   = i_TX_Byte;
          period_next = effective_period(i_Period, DEFAULT_P);
          count_next  = '0;
          index_next  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          count_next = '0;
        end else begin
          count_next = count_reg + PERIOD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          count_next = '0;
          index_next = index_reg + 3'd1;
          if (index_reg == 3'd7) state_next = STOP;
        end else begin
          count_next = count_reg + PERIOD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + PERIOD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are precomputed from the state being entered so they register cleanly.
    serial_next = 1'b1;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = data_next[index_next];
      default: serial_next = 1'b1;
    endcase
    active_next = (state_next != IDLE);
    done_next   = (state_reg == STOP) && (state_next == IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= '0;
      index_reg  <= '0;
      data_reg   <= '0;
      serial_reg <= 1'b1;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      period_reg <= period_next;
      index_reg  <= index_next;
      data_reg   <= data_next;
      serial_reg <= serial_next;
      active_reg <= active_next;
      done_reg   <= done_next;
    end
  end

  assign o_TX_Serial = serial_reg;
  assign o_TX_Active = active_reg;
  assign o_TX_Done   = done_reg;

endmodule
